// File: rtl/hs4_rx_bridge_if.sv
// Port bundle for hs4_rx_bridge: four-phase receive side plus valid/ready drain side.
// The bridge uses the slave modport. The environment that drives the bridge uses master.
interface hs4_rx_bridge_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             req_in;
    logic [WIDTH-1:0] data_in;
    logic             ack_out;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             proto_err;

    modport slave (
        input  req_in, data_in, out_ready,
        output ack_out, out_valid, out_data, count, proto_err
    );

    modport master (
        output req_in, data_in, out_ready,
        input  ack_out, out_valid, out_data, count, proto_err
    );
endinterface

// File: rtl/hs4_rx_bridge.sv
// Clocked receiver for a four-phase bundled-data channel driven from prsim.
// Tokens are synchronized, acknowledged, queued in a FIFO and drained over valid/ready.
module hs4_rx_bridge #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    hs4_rx_bridge_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_p_q, req_p_d;
    logic                   ack_q, ack_d;
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   out_valid_q, out_valid_d;
    logic                   proto_err_q, proto_err_d;
    logic [WIDTH-1:0]       mem [DEPTH];

    logic req_s;
    logic full;
    logic push;
    logic pop;

    // Only the last synchronizer stage may feed logic; data_in relies on the
    // synchronizer delay for its bundling margin and is never synchronized.
    assign req_s = sync_q[SYNC_STAGES-1];
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = out_valid_q && bus.out_ready;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], bus.req_in};
        req_p_d     = req_s;
        state_d     = state_q;
        ack_d       = ack_q;
        proto_err_d = proto_err_q;
        push        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_s && !full) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = HOLD;
                end else if (req_p_q && !req_s) begin
                    proto_err_d = 1'b1;
                end
            end
            HOLD: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end else if (!req_p_q) begin
                    proto_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        out_valid_d = (count_d != '0);
    end

    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            req_p_q     <= 1'b0;
            ack_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            req_p_q     <= req_p_d;
            ack_q       <= ack_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            proto_err_q <= proto_err_d;
        end
    end

    // NOTE: storage has no reset; pointers and count define which entries are live, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= bus.data_in;
        end
    end

    assign bus.ack_out   = ack_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_valid_q ? mem[rd_ptr_q[AW-1:0]] : '0;
    assign bus.count     = count_q;
    assign bus.proto_err = proto_err_q;

    // In HOLD req_s has been high since capture, so a fresh rise here means the sender broke the handshake.
    a_no_rerise_in_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(state_q == HOLD && req_s && !req_p_q)
    );
endmodule

// File: tb/tb_hs4_rx_bridge.sv
// Directed bench for hs4_rx_bridge (WIDTH=8, DEPTH=4, SYNC_STAGES=2).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_hs4_rx_bridge;
    logic clk;
    logic rst_n;

    hs4_rx_bridge_if #(.WIDTH(8), .DEPTH(4)) bus ();

    hs4_rx_bridge #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] got_q [$];
    bit         mon_en  = 1'b0;
    int         max_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic level, input int max_cycles, input string tag);
        for (int i = 0; i < max_cycles; i++) begin
            if (bus.ack_out === level) break;
            step(1);
        end
        check(tag, 32'(bus.ack_out), 32'(level));
    endtask

    task automatic send_token(input logic [7:0] d);
        bus.data_in = d;
        bus.req_in  = 1'b1;
        wait_ack(1'b1, 12, "ack_rise");
        bus.req_in  = 1'b0;
        wait_ack(1'b0, 12, "ack_fall");
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_in    = 1'b0;
        bus.data_in   = 8'h00;
        bus.out_ready = 1'b0;
        step(3);
        check("rst_ack",       32'(bus.ack_out),   32'h0);
        check("rst_valid",     32'(bus.out_valid), 32'h0);
        check("rst_count",     32'(bus.count),     32'h0);
        check("rst_data",      32'(bus.out_data),  32'h0);
        check("rst_proto_err", 32'(bus.proto_err), 32'h0);
        rst_n = 1'b1;

        // T1: single token, exact rise/fall latency
        bus.data_in = 8'hA5;
        bus.req_in  = 1'b1;
        step(2);
        check("t1_ack_e2",  32'(bus.ack_out),   32'h0);
        check("t1_valid_e2",32'(bus.out_valid), 32'h0);
        step(1);
        check("t1_ack_e3",  32'(bus.ack_out),   32'h1);
        check("t1_valid",   32'(bus.out_valid), 32'h1);
        check("t1_data",    32'(bus.out_data),  32'hA5);
        check("t1_count",   32'(bus.count),     32'h1);
        bus.req_in = 1'b0;
        step(2);
        check("t1_ack_fall_e2", 32'(bus.ack_out), 32'h1);
        step(1);
        check("t1_ack_fall_e3", 32'(bus.ack_out), 32'h0);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        check("t1_pop_count", 32'(bus.count),     32'h0);
        check("t1_pop_valid", 32'(bus.out_valid), 32'h0);

        // T2: fill and backpressure
        for (int i = 1; i <= 4; i++) send_token(8'(i));
        check("t2_count_full", 32'(bus.count),    32'h4);
        check("t2_head",       32'(bus.out_data), 32'h01);
        bus.data_in = 8'h05;
        bus.req_in  = 1'b1;
        step(6);
        check("t2_backpressure_ack", 32'(bus.ack_out), 32'h0);
        check("t2_backpressure_cnt", 32'(bus.count),   32'h4);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        check("t2_pop_count", 32'(bus.count),   32'h3);
        check("t2_pop_ack",   32'(bus.ack_out), 32'h0);
        step(1);
        check("t2_fifth_ack",   32'(bus.ack_out), 32'h1);
        check("t2_fifth_count", 32'(bus.count),   32'h4);
        bus.req_in = 1'b0;
        wait_ack(1'b0, 12, "t2_fifth_fall");
        bus.out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("t2_drain_data", 32'(bus.out_data), 32'(i));
            step(1);
        end
        check("t2_drain_empty", 32'(bus.out_valid), 32'h0);

        // T3: streaming across pointer wrap
        got_q.delete();
        max_cnt = 0;
        mon_en  = 1'b1;
        for (int i = 0; i < 10; i++) send_token(8'(i));
        step(2);
        mon_en = 1'b0;
        check("t3_num_popped", 32'(got_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < got_q.size()) check("t3_order", 32'(got_q[i]), 32'(i));
        end
        check("t3_max_count", 32'(max_cnt), 32'd1);
        check("t3_end_count", 32'(bus.count), 32'h0);

        // T4: push and pop on the same edge
        bus.out_ready = 1'b0;
        send_token(8'h20);
        send_token(8'h21);
        check("t4_count_before", 32'(bus.count), 32'h2);
        bus.data_in = 8'h22;
        bus.req_in  = 1'b1;
        step(2);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        check("t4_ack",   32'(bus.ack_out),  32'h1);
        check("t4_count", 32'(bus.count),    32'h2);
        check("t4_head",  32'(bus.out_data), 32'h21);
        bus.req_in = 1'b0;
        wait_ack(1'b0, 12, "t4_fall");
        bus.out_ready = 1'b1;
        step(1);
        check("t4_next", 32'(bus.out_data), 32'h22);
        step(1);
        bus.out_ready = 1'b0;
        check("t4_empty", 32'(bus.count), 32'h0);

        // T5: request withdrawn before acknowledge (FIFO full, so no capture)
        for (int i = 0; i < 4; i++) send_token(8'h30 + 8'(i));
        check("t5_no_err_yet", 32'(bus.proto_err), 32'h0);
        bus.data_in = 8'h34;
        bus.req_in  = 1'b1;
        step(2);
        bus.req_in = 1'b0;
        step(6);
        check("t5_proto_err", 32'(bus.proto_err), 32'h1);
        check("t5_ack",       32'(bus.ack_out),   32'h0);
        check("t5_count",     32'(bus.count),     32'h4);
        check("t5_head",      32'(bus.out_data),  32'h30);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        step(4);
        check("t5_sticky",     32'(bus.proto_err), 32'h1);
        check("t5_pop_count",  32'(bus.count),     32'h3);
        check("t5_no_capture", 32'(bus.ack_out),   32'h0);
        rst_n = 1'b0;
        #2;
        check("t5_rst_err",   32'(bus.proto_err), 32'h0);
        check("t5_rst_count", 32'(bus.count),     32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // T6: reset while holding acknowledge, then recapture
        bus.data_in = 8'h55;
        bus.req_in  = 1'b1;
        wait_ack(1'b1, 12, "t6_first_ack");
        rst_n = 1'b0;
        #1;
        check("t6_rst_ack",   32'(bus.ack_out),   32'h0);
        check("t6_rst_count", 32'(bus.count),     32'h0);
        check("t6_rst_valid", 32'(bus.out_valid), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2);
        check("t6_ack_e2", 32'(bus.ack_out), 32'h0);
        step(1);
        check("t6_ack_e3", 32'(bus.ack_out),  32'h1);
        check("t6_count",  32'(bus.count),    32'h1);
        check("t6_data",   32'(bus.out_data), 32'h55);
        bus.req_in = 1'b0;
        wait_ack(1'b0, 12, "t6_fall");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
